// File: rtl/adc_capture_seq.sv
`default_nettype none
// ============================================================================
// adc_capture_seq : multi-channel ADC frame serialiser into a shared FIFO
// Revision        : 1.0
// ============================================================================
module adc_capture_seq #(
  parameter int PRECISION  = 10,
  parameter int NUM_CH     = 4,
  parameter int DEPTH_LOG2 = 10,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*PRECISION-1:0] adc_code_in,
  input  logic                        sample_valid,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [LEN_WIDTH-1:0]        capture_len,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        flush,
  input  logic                        rd_en,
  output logic [15:0]                 rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        full,
  output logic [DEPTH_LOG2:0]         word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic                        overrun
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   C_ONE_CNT = 1;
  localparam logic [DEPTH_LOG2-1:0] C_ONE_PTR = 1;
  localparam logic [LEN_WIDTH-1:0]  C_ONE_LEN = 1;
  localparam logic [NUM_CH-1:0]     C_ONE_CH  = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                        r_state;
  logic [NUM_CH-1:0]             r_en_q;
  logic [LEN_WIDTH-1:0]          r_len_q;
  logic [LEN_WIDTH-1:0]          r_frames_done;
  logic [NUM_CH*PRECISION-1:0]   r_frame_q;
  logic [NUM_CH-1:0]             r_pending;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_overrun;

  logic [15:0]                   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]         r_wr_ptr;
  logic [DEPTH_LOG2-1:0]         r_rd_ptr;
  logic [DEPTH_LOG2:0]           r_count;
  logic                          r_full;
  logic                          r_empty;
  logic [15:0]                   r_rd_data;
  logic                          r_rd_valid;
  logic                          r_overflow;

  logic [NUM_CH-1:0]             w_sel;
  logic                          w_last;
  logic                          w_serialising;
  logic [3:0]                    w_ch;
  logic [PRECISION-1:0]          w_code;
  logic [15:0]                   w_word;
  logic [LEN_WIDTH-1:0]          w_frames_next;
  logic                          w_wr_req;
  logic                          w_wr_ok;
  logic                          w_rd;
  logic [DEPTH_LOG2:0]           w_count_next;

  // r_pending holds the channels of the current frame not yet written;
  // its lowest set bit is the channel being emitted this cycle.
  assign w_sel         = r_pending & (~r_pending + C_ONE_CH);
  assign w_last        = (r_pending != '0) && ((r_pending & (r_pending - C_ONE_CH)) == '0);
  assign w_serialising = (r_state == S_CAPTURE) && (r_pending != '0);
  assign w_frames_next = r_frames_done + C_ONE_LEN;

  always_comb begin
    w_ch   = '0;
    w_code = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel[k]) begin
        w_ch   = 4'(k);
        w_code = r_frame_q[k*PRECISION +: PRECISION];
      end
    end
  end

  always_comb begin
    w_word                  = '0;
    w_word[15:12]           = w_ch;
    w_word[PRECISION-1:0]   = w_code;
  end

  // Abort truncates immediately, so the word due in the abort cycle is not written.
  assign w_wr_req = w_serialising && !abort;
  assign w_rd     = rd_en && !r_empty && !flush;
  assign w_wr_ok  = w_wr_req && !flush && (!r_full || w_rd);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_ok, w_rd})
      2'b10:   w_count_next = r_count + C_ONE_CNT;
      2'b01:   w_count_next = r_count - C_ONE_CNT;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_en_q        <= '0;
      r_len_q       <= '0;
      r_frames_done <= '0;
      r_frame_q     <= '0;
      r_pending     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (flush) begin
        r_overrun <= 1'b0;
      end else if (w_serialising && !w_last && sample_valid) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (arm && (ch_enable != '0)) begin
            r_en_q        <= ch_enable;
            r_len_q       <= capture_len;
            r_frames_done <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (sample_valid) begin
            r_frame_q <= adc_code_in;
            r_pending <= r_en_q;
            r_state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_pending != '0) begin
            if (w_last) begin
              r_frames_done <= w_frames_next;
              if ((r_len_q != '0) && (w_frames_next == r_len_q)) begin
                r_pending <= '0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= S_IDLE;
              end else if (sample_valid) begin
                r_frame_q <= adc_code_in;
                r_pending <= r_en_q;
              end else begin
                r_pending <= '0;
              end
            end else begin
              r_pending <= r_pending & ~w_sel;
            end
          end else if (sample_valid) begin
            r_frame_q <= adc_code_in;
            r_pending <= r_en_q;
          end
        end
        default: begin
          r_pending <= '0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + C_ONE_PTR;
      end
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + C_ONE_PTR;
        r_rd_data  <= r_mem[r_rd_ptr];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
      if (w_wr_req && r_full && !w_rd) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_DEPTH);
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage is left unreset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign empty      = r_empty;
  assign full       = r_full;
  assign word_count = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_seq.sv
`default_nettype none
// ============================================================================
// tb_adc_capture_seq : scoreboard bench for adc_capture_seq (depth 8, 4 ch)
// Revision           : 1.0
// ============================================================================
module tb_adc_capture_seq;

  localparam int P = 10;
  localparam int N = 4;
  localparam int D = 3;
  localparam int L = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*P-1:0] adc_code_in;
  logic           sample_valid;
  logic [N-1:0]   ch_enable;
  logic [L-1:0]   capture_len;
  logic           arm;
  logic           abort;
  logic           flush;
  logic           rd_en;
  logic [15:0]    rd_data;
  logic           rd_valid;
  logic           empty;
  logic           full;
  logic [D:0]     word_count;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           overrun;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  adc_capture_seq #(
    .PRECISION (P),
    .NUM_CH    (N),
    .DEPTH_LOG2(D),
    .LEN_WIDTH (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adc_code_in (adc_code_in),
    .sample_valid(sample_valid),
    .ch_enable   (ch_enable),
    .capture_len (capture_len),
    .arm         (arm),
    .abort       (abort),
    .flush       (flush),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard: every word read out must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL readout: got %h, required no word (queue empty)", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          bad++;
          $display("FAIL readout: got %h, required %h", rd_data, mon_exp);
        end
      end
    end
  end

  function automatic logic [P-1:0] code_of(input int f, input int k);
    return P'((f * 37 + k * 91 + 17) % 1024);
  endfunction

  function automatic logic [N*P-1:0] bus_of(input int f);
    logic [N*P-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) b[k*P +: P] = code_of(f, k);
    return b;
  endfunction

  function automatic logic [15:0] word_of(input int k, input logic [P-1:0] c);
    return {4'(k), 2'b00, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int f, input logic [N-1:0] en);
    for (int k = 0; k < N; k++)
      if (en[k]) exp_q.push_back(word_of(k, code_of(f, k)));
  endtask

  task automatic do_arm(input logic [N-1:0] en, input logic [L-1:0] len);
    ch_enable   = en;
    capture_len = len;
    arm         = 1'b1;
    tick();
    arm         = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic send_frame(input logic [N*P-1:0] b);
    adc_code_in  = b;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (empty === 1'b0 && n < 64) begin
      rd_en = 1'b1;
      tick();
      n++;
    end
    rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adc_code_in = '0; sample_valid = 0; ch_enable = '0; capture_len = '0;
    arm = 0; abort = 0; flush = 0; rd_en = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if ({empty, full, word_count, rd_valid, rd_data, busy, done, overflow, overrun}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: empty=%b full=%b cnt=%0d rv=%b rd=%h busy=%b done=%b ovf=%b ovr=%b, required empty=1 rest 0",
               empty, full, word_count, rd_valid, rd_data, busy, done, overflow, overrun);
    end
    // arm with no channels enabled must be ignored
    do_arm(4'b0000, 16'd1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL arm_no_channels: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    do_flush();
    do_arm(4'b1011, 16'd1);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h1022);
    exp_q.push_back(16'h3044);
    send_frame({10'h044, 10'h033, 10'h022, 10'h011});
    wait_done(ok);
    total++;
    if (!ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    total++;
    if (word_count !== 4'd3) begin
      bad++;
      $display("FAIL single_count: got %0d, required 3", word_count);
    end
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_leftover: %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_flush();
    do_arm(4'b1111, 16'd1);
    push_frame(1, 4'b1111);
    send_frame(bus_of(1));
    tick();
    send_frame(bus_of(2));
    wait_done(ok);
    total++;
    if (!ok || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_flag: done=%b overrun=%b, required 1/1", done, overrun);
    end
    total++;
    if (word_count !== 4'd4) begin
      bad++;
      $display("FAIL overrun_count: got %0d, required 4", word_count);
    end
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL overrun_leftover: %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_flush();
    total++;
    if (overrun !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL flush_clears: overrun=%b overflow=%b, required 0/0", overrun, overflow);
    end
    do_arm(4'b1111, 16'd3);
    push_frame(3, 4'b1111);
    push_frame(4, 4'b1111);
    for (int f = 3; f <= 5; f++) begin
      send_frame(bus_of(f));
      repeat (5) tick();
    end
    wait_done(ok);
    total++;
    if (!ok || full !== 1'b1 || word_count !== 4'd8 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_state: done=%b full=%b cnt=%0d ovf=%b, required 1/1/8/1",
               done, full, word_count, overflow);
    end
    drain();
    total++;
    if (exp_q.size() != 0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_readback: missing=%0d ovf=%b, required 0 missing, ovf sticky 1",
               exp_q.size(), overflow);
    end
  endtask

  task automatic test_rw_at_full();
    bit ok;
    do_flush();
    do_arm(4'b1111, 16'd3);
    push_frame(6, 4'b1111);
    push_frame(7, 4'b1111);
    push_frame(8, 4'b1111);
    send_frame(bus_of(6));
    repeat (5) tick();
    send_frame(bus_of(7));
    repeat (5) tick();
    total++;
    if (full !== 1'b1 || word_count !== 4'd8) begin
      bad++;
      $display("FAIL rw_prefill: full=%b cnt=%0d, required 1/8", full, word_count);
    end
    send_frame(bus_of(8));
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (full !== 1'b1 || word_count !== 4'd8) begin
        bad++;
        $display("FAIL rw_hold_full[%0d]: full=%b cnt=%0d, required 1/8", i, full, word_count);
      end
    end
    rd_en = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || overflow !== 1'b0) begin
      bad++;
      $display("FAIL rw_no_overflow: done=%b ovf=%b, required 1/0", done, overflow);
    end
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rw_leftover: %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_continuous_abort();
    bit ok;
    do_flush();
    rd_en = 1'b1;
    do_arm(4'b1111, 16'd0);
    for (int f = 10; f <= 14; f++) begin
      push_frame(f, 4'b1111);
      send_frame(bus_of(f));
      repeat (5) tick();
    end
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL cont_running: busy=%b done=%b, required 1/0", busy, done);
    end
    // abort lands while channel 1 of frame 15 is due: only channel 0 survives
    exp_q.push_back(word_of(0, code_of(15, 0)));
    send_frame(bus_of(15));
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: busy=%b done=%b, required 0/0", busy, done);
    end
    repeat (5) tick();
    total++;
    if (exp_q.size() != 0 || word_count !== 4'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_words: missing=%0d cnt=%0d ovf=%b, required 0/0/0",
               exp_q.size(), word_count, overflow);
    end
    rd_en = 1'b0;
    do_arm(4'b0100, 16'd1);
    exp_q.push_back(word_of(2, code_of(16, 2)));
    send_frame(bus_of(16));
    wait_done(ok);
    total++;
    if (!ok || busy !== 1'b0 || word_count !== 4'd1) begin
      bad++;
      $display("FAIL rearm: done=%b busy=%b cnt=%0d, required 1/0/1", done, busy, word_count);
    end
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rearm_leftover: %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_capture();
    do_flush();
    do_arm(4'b1111, 16'd0);
    send_frame(bus_of(20));
    tick();
    total++;
    if (word_count !== 4'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: cnt=%0d busy=%b, required 1/1", word_count, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({empty, full, word_count, rd_valid, rd_data, busy, done, overflow, overrun}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: empty=%b full=%b cnt=%0d rv=%b rd=%h busy=%b done=%b ovf=%b ovr=%b, required empty=1 rest 0",
               empty, full, word_count, rd_valid, rd_data, busy, done, overflow, overrun);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    send_frame(bus_of(21));
    repeat (3) tick();
    total++;
    if (empty !== 1'b1 || word_count !== 4'd0) begin
      bad++;
      $display("FAIL idle_strobe: empty=%b cnt=%0d, required 1/0", empty, word_count);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_empty: rd_valid=%b, required 0", rd_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_overflow();
    test_rw_at_full();
    test_continuous_abort();
    test_reset_mid_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
